// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
// Module      : main_memory
// Description : Word-addressed memory responder with fixed access latency,
//               sitting behind the cache on the maddr/mout/min/mre/mwe/mready
//               interface.
// Revision    : 1.0 - initial release
// ============================================================================
module main_memory #(
   parameter int ADDR_WIDTH = 64,
   parameter int WORD_WIDTH = 64,
   parameter int SIZE_BITS  = 10,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WORD_WIDTH-1:0] din,
   output logic [WORD_WIDTH-1:0] dout,
   input  logic                  re,
   input  logic                  we,
   output logic                  ready,
   output logic [31:0]           read_count,
   output logic [31:0]           write_count
);

   localparam int              C_DEPTH    = 1 << SIZE_BITS;
   localparam int              C_CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(LATENCY - 1);

   generate
      if (LATENCY < 1) begin : g_latency_check
         $error("main_memory: LATENCY must be >= 1");
      end
      if (ADDR_WIDTH > SIZE_BITS) begin : g_addr_hi
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = ^addr[ADDR_WIDTH-1:SIZE_BITS];
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_BUSY_READ  = 2'd1,
      ST_BUSY_WRITE = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [C_CNT_W-1:0]     r_cnt;
   logic [C_CNT_W-1:0]     w_cnt_nxt;
   logic                   w_capture;
   logic                   w_rd_done;
   logic                   w_wr_done;
   logic                   r_ready;
   logic [SIZE_BITS-1:0]   r_addr;
   logic [WORD_WIDTH-1:0]  r_din;
   logic [WORD_WIDTH-1:0]  r_dout;
   logic [31:0]            r_read_count;
   logic [31:0]            r_write_count;
   logic [WORD_WIDTH-1:0]  r_mem [0:C_DEPTH-1];

   // Requests are only looked at in IDLE, so anything arriving while busy,
   // including on the completing edge, falls through untouched.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_rd_done   = 1'b0;
      w_wr_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (re) begin
               w_state_nxt = ST_BUSY_READ;
               w_cnt_nxt   = C_CNT_LOAD;
               w_capture   = 1'b1;
            end else if (we) begin
               w_state_nxt = ST_BUSY_WRITE;
               w_cnt_nxt   = C_CNT_LOAD;
               w_capture   = 1'b1;
            end
         end
         ST_BUSY_READ: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
               w_rd_done   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_BUSY_WRITE: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
               w_wr_done   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_ready       <= 1'b1;
         r_addr        <= '0;
         r_din         <= '0;
         r_dout        <= '0;
         r_read_count  <= '0;
         r_write_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= (w_state_nxt == ST_IDLE);
         if (w_capture) begin
            r_addr <= addr[SIZE_BITS-1:0];
            r_din  <= din;
         end
         if (w_rd_done) begin
            r_dout       <= r_mem[r_addr];
            r_read_count <= r_read_count + 32'd1;
         end
         if (w_wr_done) begin
            r_write_count <= r_write_count + 32'd1;
         end
      end
   end

   // Storage has no reset; an abandoned write never reaches here because
   // reset forces the state back to IDLE before the next edge.
   always_ff @(posedge clk) begin
      if (w_wr_done) begin
         r_mem[r_addr] <= r_din;
      end
   end

   assign dout        = r_dout;
   assign ready       = r_ready;
   assign read_count  = r_read_count;
   assign write_count = r_write_count;

endmodule
`default_nettype wire

// File: tb/tb_main_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_memory
// Description : Self-checking bench for main_memory (vector table, directed
//               corner sequences, random traffic against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory;

   localparam int C_LAT = 4;

   logic        clk;
   logic        rst;
   logic [63:0] addr;
   logic [63:0] din;
   logic [63:0] dout;
   logic        re;
   logic        we;
   logic        ready;
   logic [31:0] read_count;
   logic [31:0] write_count;

   main_memory #(
      .ADDR_WIDTH (64),
      .WORD_WIDTH (64),
      .SIZE_BITS  (10),
      .LATENCY    (C_LAT)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .addr        (addr),
      .din         (din),
      .dout        (dout),
      .re          (re),
      .we          (we),
      .ready       (ready),
      .read_count  (read_count),
      .write_count (write_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        re;
      logic        we;
      logic [63:0] addr;
      logic [63:0] din;
      logic [63:0] exp_dout;
      logic [31:0] exp_rc;
      logic [31:0] exp_wc;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] mdl_mem [int];
   logic [63:0] exp_dout;
   logic [31:0] exp_rc;
   logic [31:0] exp_wc;
   int          written_list[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   // Reference behaviour: a completed access is just an array update/lookup
   // on the low 10 address bits; re wins over we.
   task automatic model_access(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d);
      int idx;
      idx = int'(a[9:0]);
      if (r) begin
         exp_dout = mdl_mem.exists(idx) ? mdl_mem[idx] : 64'h0;
         exp_rc++;
      end else if (w) begin
         mdl_mem[idx] = d;
         exp_wc++;
         written_list.push_back(idx);
      end
   endtask

   task automatic do_req(input logic r, input logic w, input logic [63:0] a,
                         input logic [63:0] d, input bit scribble, input string nm);
      int low;
      @(negedge clk);
      re = r; we = w; addr = a; din = d;
      @(posedge clk);
      #1;
      re = 1'b0; we = 1'b0;
      if (scribble) begin
         addr = {$urandom, $urandom};
         din  = {$urandom, $urandom};
      end
      model_access(r, w, a, d);
      low = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ready) break;
         low++;
      end
      check({nm, " ready_low_cycles"}, 64'(low), 64'(C_LAT));
      check({nm, " dout"}, dout, exp_dout);
      check({nm, " read_count"}, 64'(read_count), 64'(exp_rc));
      check({nm, " write_count"}, 64'(write_count), 64'(exp_wc));
   endtask

   vec_t vecs [7];

   initial begin
      int low;
      vecs[0] = '{1'b0, 1'b1, 64'd5,    64'hDEADBEEF, 64'h0,        32'd0, 32'd1};
      vecs[1] = '{1'b1, 1'b0, 64'd5,    64'h0,        64'hDEADBEEF, 32'd1, 32'd1};
      vecs[2] = '{1'b0, 1'b1, 64'd1024, 64'h1234,     64'hDEADBEEF, 32'd1, 32'd2};
      vecs[3] = '{1'b1, 1'b0, 64'd0,    64'h0,        64'h1234,     32'd2, 32'd2};
      vecs[4] = '{1'b0, 1'b1, 64'd7,    64'hAA,       64'h1234,     32'd2, 32'd3};
      vecs[5] = '{1'b1, 1'b1, 64'd7,    64'h55,       64'hAA,       32'd3, 32'd3};
      vecs[6] = '{1'b1, 1'b0, 64'd7,    64'h0,        64'hAA,       32'd4, 32'd3};

      rst = 1'b0; re = 1'b0; we = 1'b0; addr = '0; din = '0;
      exp_dout = '0; exp_rc = '0; exp_wc = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset ready", 64'(ready), 64'd1);
      check("reset dout", dout, 64'h0);
      check("reset read_count", 64'(read_count), 64'd0);
      check("reset write_count", 64'(write_count), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle ready", 64'(ready), 64'd1);
      end

      for (int i = 0; i < 7; i++) begin
         do_req(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].din, 1'b1, $sformatf("vec%0d", i));
         check($sformatf("vec%0d table dout", i), dout, vecs[i].exp_dout);
         check($sformatf("vec%0d table rc", i), 64'(read_count), 64'(vecs[i].exp_rc));
         check($sformatf("vec%0d table wc", i), 64'(write_count), 64'(vecs[i].exp_wc));
      end

      // Write at 3, read pulses on busy cycle 2 and on the completing edge.
      @(negedge clk);
      we = 1'b1; addr = 64'd3; din = 64'h3333;
      @(posedge clk);
      #1;
      we = 1'b0;
      model_access(1'b0, 1'b1, 64'd3, 64'h3333);
      low = 0;
      for (int i = 1; i <= C_LAT + 2; i++) begin
         @(negedge clk);
         if (!ready) low++;
         re   = (i == 2 || i == 4);
         addr = 64'd5;
      end
      re = 1'b0;
      check("busy ready_low_cycles", 64'(low), 64'(C_LAT));
      check("busy write_count", 64'(write_count), 64'(exp_wc));
      check("busy read_count", 64'(read_count), 64'(exp_rc));
      check("busy dout", dout, exp_dout);
      check("busy ready after", 64'(ready), 64'd1);

      // Reset in the middle of a write to 9.
      do_req(1'b0, 1'b1, 64'd9, 64'h77, 1'b0, "pre-reset write");
      @(negedge clk);
      we = 1'b1; addr = 64'd9; din = 64'h99;
      @(posedge clk);
      #1;
      we = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      exp_rc = '0; exp_wc = '0; exp_dout = '0;
      check("midrst ready", 64'(ready), 64'd1);
      check("midrst dout", dout, 64'h0);
      check("midrst write_count", 64'(write_count), 64'd0);
      check("midrst read_count", 64'(read_count), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst ready after", 64'(ready), 64'd1);
      do_req(1'b1, 1'b0, 64'd9, 64'h0, 1'b0, "midrst readback");

      // Random traffic over a small window of addresses with random upper bits.
      for (int n = 0; n < 40; n++) begin
         int          kind;
         logic [63:0] a;
         logic [63:0] d;
         kind = int'($urandom_range(0, 2));
         a    = {$urandom, $urandom};
         d    = {$urandom, $urandom};
         if (kind != 0) begin
            a[9:0] = 10'(written_list[$urandom_range(0, written_list.size() - 1)]);
         end else begin
            a[9:0] = 10'($urandom_range(0, 15));
         end
         do_req(kind != 0, kind != 1, a, d, 1'b1, $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
